ddr_port_arbiter: RTL

//  Round-robin arbiter sharing the single DDR read/write port (port A of ddr_mem_dualport) between N

---
 rtl/ddr_arb_pkg.sv | 25 ++
 rtl/ddr_tag_fifo.sv | 66 ++++++
 rtl/ddr_port_arbiter.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/ddr_arb_pkg.sv
// ============================================================================
// Module  : ddr_arb_pkg
// Brief   : Shared types and sizing helpers for the DDR port arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ddr_arb_pkg;

  localparam int MAX_OUTST_DEF = 8;
  localparam int TAG_MAX_W     = 3;

  // Widest requester tag the arbiter supports (N_REQ up to 8).
  typedef logic [TAG_MAX_W-1:0] tag_t;

  function automatic int req_idx_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ddr_tag_fifo.sv
// ============================================================================
// Module  : ddr_tag_fifo
// Brief   : Synchronous FIFO holding requester tags of reads in flight to DDR.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ddr_tag_fifo
  import ddr_arb_pkg::*;
#(
  parameter int DEPTH = MAX_OUTST_DEF,
  parameter int WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/ddr_port_arbiter.sv
// ============================================================================
// Module  : ddr_port_arbiter
// Brief   : Round-robin arbiter sharing one DDR port between N_REQ requesters,
//           with in-order read-response routing. Optional macro
//           ARB_PERF_CNT_EN adds per-requester grant and stall counters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ddr_port_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int N_REQ     = 3,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 8,
  parameter int MAX_OUTST = MAX_OUTST_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ-1:0]         req_write,
  input  logic [N_REQ*ADDR_W-1:0]  req_addr,
  input  logic [N_REQ*DATA_W-1:0]  req_wdata,
  output logic [N_REQ-1:0]         req_ready,
  output logic [N_REQ-1:0]         resp_valid,
  output logic [DATA_W-1:0]        resp_rdata,
  output logic                     mem_req_valid,
  output logic                     mem_req_write,
  output logic [ADDR_W-1:0]        mem_req_addr,
  output logic [DATA_W-1:0]        mem_req_wdata,
  input  logic                     mem_resp_valid,
  input  logic [DATA_W-1:0]        mem_resp_rdata,
  output logic                     err_orphan
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [N_REQ*32-1:0]      perf_grants,
  output logic [31:0]              perf_stall
`endif
);

  localparam int               IDX_W   = req_idx_w(N_REQ);
  localparam int               CNT_W   = $clog2(MAX_OUTST) + 1;
  localparam logic [IDX_W:0]   N_REQ_X = (IDX_W+1)'(N_REQ);
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(N_REQ - 1);
  localparam logic [N_REQ-1:0] ONE     = N_REQ'(1);

  logic [ADDR_W-1:0] addr_arr  [N_REQ];
  logic [DATA_W-1:0] wdata_arr [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
    assign wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
  end

  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic              mem_req_valid_q, mem_req_valid_d;
  logic              mem_req_write_q, mem_req_write_d;
  logic [ADDR_W-1:0] mem_req_addr_q, mem_req_addr_d;
  logic [DATA_W-1:0] mem_req_wdata_q, mem_req_wdata_d;
  logic [N_REQ-1:0]  resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              err_orphan_q, err_orphan_d;

  logic [N_REQ-1:0]  eligible;
  logic              read_limit;
  logic              grant;
  logic [IDX_W-1:0]  winner;
  logic [IDX_W:0]    idx_x;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [IDX_W-1:0]  fifo_head;
  logic [CNT_W-1:0]  fifo_count;
  tag_t              head_tag;

  ddr_tag_fifo #(
    .DEPTH (MAX_OUTST),
    .WIDTH (IDX_W)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (winner),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Registered in-flight count only: a pop this cycle frees a slot next cycle.
  assign read_limit = (fifo_count >= CNT_W'(MAX_OUTST));
  assign eligible   = req_valid & (req_write | {N_REQ{~read_limit}});
  assign head_tag   = tag_t'(fifo_head);

  // Scan from highest to lowest offset so the last hit is the first at/after ptr.
  always_comb begin
    grant  = 1'b0;
    winner = '0;
    idx_x  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx_x = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (idx_x >= N_REQ_X) idx_x = idx_x - N_REQ_X;
      if (eligible[idx_x[IDX_W-1:0]]) begin
        grant  = 1'b1;
        winner = idx_x[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    req_ready       = grant ? (ONE << winner) : '0;
    ptr_d           = ptr_q;
    mem_req_valid_d = grant;
    mem_req_write_d = mem_req_write_q;
    mem_req_addr_d  = mem_req_addr_q;
    mem_req_wdata_d = mem_req_wdata_q;
    fifo_push       = grant & ~req_write[winner] & ~fifo_full;
    fifo_pop        = mem_resp_valid & ~fifo_empty;
    resp_valid_d    = '0;
    resp_rdata_d    = resp_rdata_q;
    err_orphan_d    = err_orphan_q | (mem_resp_valid & fifo_empty);

    if (grant) begin
      ptr_d           = (winner == LAST) ? '0 : winner + IDX_W'(1);
      mem_req_write_d = req_write[winner];
      mem_req_addr_d  = addr_arr[winner];
      mem_req_wdata_d = wdata_arr[winner];
    end

    if (fifo_pop) begin
      resp_valid_d = ONE << head_tag;
      resp_rdata_d = mem_resp_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q           <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_write_q <= 1'b0;
      mem_req_addr_q  <= '0;
      mem_req_wdata_q <= '0;
      resp_valid_q    <= '0;
      resp_rdata_q    <= '0;
      err_orphan_q    <= 1'b0;
    end else begin
      ptr_q           <= ptr_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_req_write_q <= mem_req_write_d;
      mem_req_addr_q  <= mem_req_addr_d;
      mem_req_wdata_q <= mem_req_wdata_d;
      resp_valid_q    <= resp_valid_d;
      resp_rdata_q    <= resp_rdata_d;
      err_orphan_q    <= err_orphan_d;
    end
  end

  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_write = mem_req_write_q;
  assign mem_req_addr  = mem_req_addr_q;
  assign mem_req_wdata = mem_req_wdata_q;
  assign resp_valid    = resp_valid_q;
  assign resp_rdata    = resp_rdata_q;
  assign err_orphan    = err_orphan_q;

`ifdef ARB_PERF_CNT_EN
  for (genvar i = 0; i < N_REQ; i++) begin : g_perf_grant
    logic [31:0] grant_cnt_q, grant_cnt_d;

    always_comb grant_cnt_d = grant_cnt_q + 32'(req_ready[i]);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) grant_cnt_q <= '0;
      else     grant_cnt_q <= grant_cnt_d;
    end

    assign perf_grants[i*32 +: 32] = grant_cnt_q;
  end

  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb stall_cnt_d = stall_cnt_q + 32'((|req_valid) & ~grant);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign perf_stall = stall_cnt_q;
`endif

endmodule

`default_nettype wire
